// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode: takes up to two instructions per
// cycle from fetch and presents the two oldest to decode, in program order.
module if_id_queue #(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       stall,
   input  logic [31:0]                in_inst1,
   input  logic                       in_inst1_en,
   input  logic [31:0]                in_inst2,
   input  logic                       in_inst2_en,
   input  logic [31:0]                in_pc,
   output logic                       in_ready,
   output logic [31:0]                out_inst1,
   output logic [31:0]                out_inst2,
   output logic [31:0]                out_pc1,
   output logic [31:0]                out_pc2,
   output logic                       out_inst1_en,
   output logic                       out_inst2_en,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Handshake: a bundle is taken on a rising edge when in_ready = 1 (and rst = 0);
   // fetch must hold the bundle while in_ready = 0. Decode has no ready on the output
   // side: the head pair is consumed whenever stall = 0 and flush = 0.

   logic [31:0]   mem_inst [DEPTH];
   logic [31:0]   mem_pc   [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW-1:0] head_next1;
   logic [AW-1:0] wr_idx2;
   logic [31:0]   pc_plus4;
   logic [1:0]    enq_n;
   logic [1:0]    deq_n;
   logic          do_enq;

   assign in_ready   = (count <= CW'(DEPTH - 2)) && !flush;
   assign do_enq     = in_ready;
   assign pc_plus4   = in_pc + 32'd4;
   assign head_next1 = head + AW'(1);
   // Inst2 lands directly behind Inst1, or at tail itself when Inst1 is absent.
   assign wr_idx2    = tail + AW'(in_inst1_en);

   always_comb begin
      enq_n = 2'd0;
      deq_n = 2'd0;
      if (do_enq) begin
         enq_n = {1'b0, in_inst1_en} + {1'b0, in_inst2_en};
      end
      if (!stall && !flush) begin
         deq_n = (count >= CW'(2)) ? 2'd2 : count[1:0];
      end
   end

   always_comb begin
      out_inst1_en = (count >= CW'(1));
      out_inst2_en = (count >= CW'(2));
      out_inst1    = 32'd0;
      out_pc1      = 32'd0;
      out_inst2    = 32'd0;
      out_pc2      = 32'd0;
      if (out_inst1_en) begin
         out_inst1 = mem_inst[head];
         out_pc1   = mem_pc[head];
      end
      if (out_inst2_en) begin
         out_inst2 = mem_inst[head_next1];
         out_pc2   = mem_pc[head_next1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + AW'(deq_n);
         tail  <= tail + AW'(enq_n);
         count <= count + CW'(enq_n) - CW'(deq_n);
      end
   end

   // Storage is never cleared; the pointers and count alone decide what is valid.
   always_ff @(posedge clk) begin
      if (!rst && do_enq) begin
         if (in_inst1_en) begin
            mem_inst[tail] <= in_inst1;
            mem_pc[tail]   <= in_pc;
         end
         if (in_inst2_en) begin
            mem_inst[wr_idx2] <= in_inst2;
            mem_pc[wr_idx2]   <= pc_plus4;
         end
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized run.
module tb_if_id_queue;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst, flush, stall;
   logic [31:0] in_inst1, in_inst2, in_pc;
   logic        in_inst1_en, in_inst2_en;
   logic        in_ready;
   logic [31:0] out_inst1, out_inst2, out_pc1, out_pc2;
   logic        out_inst1_en, out_inst2_en;
   logic [$clog2(DEPTH):0] count;

   int passed = 0;
   int total  = 0;

   logic [31:0] exp_inst_q[$];
   logic [31:0] exp_pc_q[$];

   if_id_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall),
      .in_inst1(in_inst1), .in_inst1_en(in_inst1_en),
      .in_inst2(in_inst2), .in_inst2_en(in_inst2_en),
      .in_pc(in_pc), .in_ready(in_ready),
      .out_inst1(out_inst1), .out_inst2(out_inst2),
      .out_pc1(out_pc1), .out_pc2(out_pc2),
      .out_inst1_en(out_inst1_en), .out_inst2_en(out_inst2_en),
      .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Compare DUT outputs with the model; called at the negedge, inputs stable.
   task automatic compare_model();
      int n;
      n = exp_inst_q.size();
      check("m_count",   64'(count), 64'(n));
      check("m_ready",   64'(in_ready), 64'((DEPTH - n) >= 2 && !flush));
      check("m_en1",     64'(out_inst1_en), 64'(n >= 1));
      check("m_en2",     64'(out_inst2_en), 64'(n >= 2));
      check("m_inst1",   64'(out_inst1), (n >= 1) ? 64'(exp_inst_q[0]) : 64'd0);
      check("m_pc1",     64'(out_pc1),   (n >= 1) ? 64'(exp_pc_q[0])   : 64'd0);
      check("m_inst2",   64'(out_inst2), (n >= 2) ? 64'(exp_inst_q[1]) : 64'd0);
      check("m_pc2",     64'(out_pc2),   (n >= 2) ? 64'(exp_pc_q[1])   : 64'd0);
   endtask

   task automatic update_model();
      int n, deq;
      bit ready;
      if (rst || flush) begin
         exp_inst_q.delete();
         exp_pc_q.delete();
         return;
      end
      n     = exp_inst_q.size();
      ready = (DEPTH - n) >= 2;
      deq   = stall ? 0 : ((n < 2) ? n : 2);
      repeat (deq) begin
         void'(exp_inst_q.pop_front());
         void'(exp_pc_q.pop_front());
      end
      if (ready) begin
         if (in_inst1_en) begin
            exp_inst_q.push_back(in_inst1);
            exp_pc_q.push_back(in_pc);
         end
         if (in_inst2_en) begin
            exp_inst_q.push_back(in_inst2);
            exp_pc_q.push_back(in_pc + 32'd4);
         end
      end
   endtask

   // Apply one cycle of inputs; on return the edge has happened (posedge + 1).
   task automatic step(input logic r, input logic f, input logic s,
                       input logic e1, input logic e2,
                       input logic [31:0] i1, input logic [31:0] i2, input logic [31:0] pc);
      rst = r; flush = f; stall = s;
      in_inst1_en = e1; in_inst2_en = e2;
      in_inst1 = i1; in_inst2 = i2; in_pc = pc;
      @(negedge clk);
      compare_model();
      update_model();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs(input logic s);
      rst = 0; flush = 0; stall = s; in_inst1_en = 0; in_inst2_en = 0;
      #1;
   endtask

   logic [31:0] pc_run;

   initial begin
      rst = 1; flush = 0; stall = 1; in_inst1_en = 0; in_inst2_en = 0;
      in_inst1 = 0; in_inst2 = 0; in_pc = 0;
      @(posedge clk); #1;

      // Reset state
      step(1, 0, 1, 1, 1, 32'hAA, 32'hBB, 32'h40);
      idle_inputs(1);
      check("rst_count", 64'(count), 64'd0);
      check("rst_ready", 64'(in_ready), 64'd1);
      check("rst_en1",   64'(out_inst1_en), 64'd0);
      check("rst_pc1",   64'(out_pc1), 64'd0);

      // Single bundle while stalled
      step(0, 0, 1, 1, 1, 32'h11, 32'h22, 32'h100);
      idle_inputs(1);
      check("b_count", 64'(count), 64'd2);
      check("b_inst1", 64'(out_inst1), 64'h11);
      check("b_pc1",   64'(out_pc1), 64'h100);
      check("b_inst2", 64'(out_inst2), 64'h22);
      check("b_pc2",   64'(out_pc2), 64'h104);
      check("b_en2",   64'(out_inst2_en), 64'd1);

      // Fill to capacity, overflow bundle ignored, then drain in order
      step(1, 0, 1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++)
         step(0, 0, 1, 1, 1, 32'(2*k), 32'(2*k+1), 32'h200 + 32'(8*k));
      idle_inputs(1);
      check("full_count", 64'(count), 64'd8);
      check("full_ready", 64'(in_ready), 64'd0);
      step(0, 0, 1, 1, 1, 32'hDEAD, 32'hBEEF, 32'h900);
      idle_inputs(1);
      check("ovf_count", 64'(count), 64'd8);
      for (int k = 0; k < 4; k++) begin
         check("drain_pc1",   64'(out_pc1), 64'(32'h200 + 32'(8*k)));
         check("drain_inst2", 64'(out_inst2), 64'(2*k+1));
         step(0, 0, 0, 0, 0, 0, 0, 0);
         check("drain_count", 64'(count), 64'(8 - 2*(k+1)));
      end

      // Count 7 blocks fetch; releasing stall drains 2 and reopens
      step(1, 0, 1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++)
         step(0, 0, 1, 1, 1, 32'h50 + 32'(k), 32'h60 + 32'(k), 32'h1000 + 32'(8*k));
      step(0, 0, 1, 1, 0, 32'h70, 0, 32'h1018);
      idle_inputs(1);
      check("c7_count", 64'(count), 64'd7);
      check("c7_ready", 64'(in_ready), 64'd0);
      step(0, 0, 0, 1, 1, 32'hEE, 32'hFF, 32'h2000);
      idle_inputs(1);
      check("c5_count", 64'(count), 64'd5);
      check("c5_ready", 64'(in_ready), 64'd1);

      // Inst2 alone at PC wrap
      step(1, 0, 1, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 1, 32'h1, 32'hCAFE, 32'hFFFF_FFFC);
      idle_inputs(1);
      check("wrap_count", 64'(count), 64'd1);
      check("wrap_inst1", 64'(out_inst1), 64'hCAFE);
      check("wrap_pc1",   64'(out_pc1), 64'h0);
      check("wrap_en2",   64'(out_inst2_en), 64'd0);

      // Flush at count 5 with enqueue and dequeue requested
      step(1, 0, 1, 0, 0, 0, 0, 0);
      step(0, 0, 1, 1, 1, 1, 2, 32'h300);
      step(0, 0, 1, 1, 1, 3, 4, 32'h308);
      step(0, 0, 1, 1, 0, 5, 0, 32'h310);
      idle_inputs(0);
      check("f5_count", 64'(count), 64'd5);
      step(0, 1, 0, 1, 1, 6, 7, 32'h318);
      idle_inputs(0);
      check("fl_count", 64'(count), 64'd0);
      check("fl_en1",   64'(out_inst1_en), 64'd0);
      check("fl_ready", 64'(in_ready), 64'd1);

      // Steady 2-in/2-out streaming across several pointer wraps
      step(1, 0, 1, 0, 0, 0, 0, 0);
      pc_run = 32'h4000;
      step(0, 0, 1, 1, 1, pc_run, pc_run + 4, pc_run);
      for (int k = 0; k < 20; k++) begin
         idle_inputs(0);
         check("st_count", 64'(count), 64'd2);
         check("st_pc1",   64'(out_pc1), 64'(32'h4000 + 32'(8*k)));
         check("st_pc2",   64'(out_pc2), 64'(32'h4004 + 32'(8*k)));
         pc_run = pc_run + 8;
         step(0, 0, 0, 1, 1, pc_run, pc_run + 4, pc_run);
      end

      // Randomized run against the model
      for (int k = 0; k < 3000; k++) begin
         logic [31:0] pc;
         pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
         step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom),
              $urandom, $urandom, pc);
      end
      @(negedge clk);
      compare_model();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning queue capacity in single instructions (power of 2, >= 4).
REQ-002 Clk  in  1  system clock; all state changes on rising edge.
REQ-003 Rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-004 Flush  in  1  discard all queued instructions (branch mispredict/exception).
REQ-005 Stall  in  1  decode not accepting; no dequeue this cycle.
REQ-006 In_Port  in  IF_ID_Port  fetch bundle: Inst1/Inst1_en at PC, Inst2/Inst2_en at PC+4.
REQ-007 In_Ready  out  1  queue can accept a full bundle this cycle.
REQ-008 Out_Inst1, Out_Inst2  out  32 each  oldest and second-oldest queued instruction.
REQ-009 Out_PC1, Out_PC2  out  32 each  PCs of Out_Inst1/Out_Inst2.
REQ-010 Out_Inst1_en, Out_Inst2_en  out  1 each  corresponding output slot valid.
REQ-011 Count  out  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-012 Storage SHALL be a circular buffer of DEPTH entries {Inst[31:0], PC[31:0]}, head/tail pointers wrapping modulo DEPTH.
REQ-013 In_Ready SHALL be combinational: 1 iff (DEPTH - Count) >= 2 and Flush = 0.
REQ-014 Enqueue SHALL occur only when In_Ready = 1; bundles presented with In_Ready = 0 SHALL be ignored (fetch holds).
REQ-015 Enqueue order: Inst1 (PC) then Inst2 (PC+4); only slots with _en = 1 are written; Inst1_en = 0, Inst2_en = 1 writes Inst2 alone with PC+4; both _en = 0 writes nothing.
REQ-016 PC+4 SHALL be computed modulo 2^32 (wrap at 0xFFFF_FFFC -> 0x0000_0000).
REQ-017 Outputs SHALL be combinational from head: Out_Inst1_en = (Count >= 1), Out_Inst2_en = (Count >= 2); invalid slots drive Inst/PC = 0.
REQ-018 Dequeue, when Stall = 0 and Flush = 0, SHALL remove min(Count, 2) entries; when Stall = 1 nothing is removed and outputs hold.
REQ-019 Simultaneous enqueue and dequeue SHALL both take effect; Count_next = Count + enq_n - deq_n; no same-cycle bypass of enqueued data to outputs.
REQ-020 In_Ready uses current Count, so enqueue never overwrites an entry being dequeued; Count SHALL never exceed DEPTH nor go below 0.
REQ-021 Flush = 1 SHALL, next cycle, set Count = 0, head = tail = 0, and discard same-cycle enqueue and dequeue; Flush overrides Stall.
REQ-022 Instruction order SHALL be preserved exactly in program order across pointer wrap.

Reset
REQ-023 Rst = 1 SHALL override Flush/Stall/enqueue; next cycle Count = 0, head = tail = 0, Out_Inst1_en = Out_Inst2_en = 0, all Out_Inst/Out_PC = 0, In_Ready = 1.
REQ-024 Rst asserted mid-operation SHALL discard all contents identically to REQ-023; storage array contents need not be cleared.

Verification
REQ-025 Reset then bundle {Inst1=0x11, Inst2=0x22, both en, PC=0x100}, Stall=1 -> next cycle Count=2, Out_Inst1=0x11/PC 0x100, Out_Inst2=0x22/PC 0x104, both en=1.
REQ-026 Stall=1, fill with 4 full bundles (DEPTH=8) -> Count=8, In_Ready=0; 5th bundle ignored; release Stall -> 4 cycles drain 2/cycle in exact order, Count 8->6->4->2->0.
REQ-027 Count=7, Stall=1 -> In_Ready=0; Stall=0 same cycle -> dequeue 2, Count=5 next, In_Ready=1 next.
REQ-028 Bundle Inst1_en=0, Inst2_en=1, PC=0xFFFF_FFFC, empty queue -> Count=1, Out_Inst1=Inst2, Out_PC1=0x0000_0000, Out_Inst2_en=0.
REQ-029 Count=5 with simultaneous full enqueue, Stall=0, Flush=1 -> next cycle Count=0, both en=0, In_Ready=1.
REQ-030 Continuous enqueue 2/dequeue 2 for 20 cycles -> pointers wrap multiple times, Count constant, output PC sequence strictly +4 in order.
